counter_minutes: RTL and testbench
==================================

Name: counter_minutes

Overview:
- Minutes stage of the clock chain; sits directly downstream of the seconds counter.
- Advances a two-digit BCD minute value (00–59) on each `tick_minute` pulse in run mode.
- Emits a one-cycle `tick_hour` pulse on the 59→00 rollover, to drive the hours stage.
- In set mode, `up`/`down` adjust the minutes directly and incoming ticks are ignored.

Parameters:
- ADJ_DIV, 1, clock cycles per adjust step while `up` or `down` is held; legal range 1..65535.
- DIV_W, 16, width of the adjust prescaler; ADJ_DIV must fit in DIV_W bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode_minute  input  1  1 = run (count ticks), 0 = set (manual adjust).
- tick_minute  input  1  one-cycle pulse from the seconds stage on the 59→00 rollover.
- up  input  1  increment request, level-sensitive, set mode only.
- down  input  1  decrement request, level-sensitive, set mode only.
- minute_unit  output  4  BCD units digit, 0..9.
- minute_ten  output  4  BCD tens digit, 0..5.
- tick_hour  output  1  registered one-cycle pulse on the run-mode 59→00 rollover.

Behaviour:
- Reset (rst=1, asynchronous):
  - minute_unit=0, minute_ten=0, tick_hour=0, prescaler=0.
  - Takes effect immediately, including mid-adjust or in the same cycle as a tick.
  - Deassertion is synchronised by the integrator; this block assumes a clean release.
- Run mode (mode_minute=1):
  - On a clk edge with tick_minute=1: value increments by 1.
  - Units 9→0 carries into the tens digit.
  - 59→00 sets tick_hour=1 for exactly the next cycle.
  - up/down are ignored. The prescaler is held at 0.
- Set mode (mode_minute=0):
  - tick_minute is ignored; a tick arriving in set mode is dropped, not queued.
  - up=1, down=0: one increment step each time the prescaler reaches ADJ_DIV-1. The prescaler then reloads to 0; otherwise it increments.
  - up=0, down=1: same cadence, one decrement step. 00→59 wraps, units 0→9 borrows from the tens digit.
  - up=down, both 0 or both 1: value holds and the prescaler clears to 0.
  - With ADJ_DIV=1, the value steps every cycle while the request is held.
  - The first step after press occurs ADJ_DIV cycles after the request is sampled high.
  - No tick_hour is ever generated in set mode, including on 59→00 and 00→59 wraps.
- Mode switch:
  - Switching mode clears the prescaler and keeps the current value.
  - A tick in the same cycle that mode_minute rises to 1 is counted, because mode is sampled on the same edge.
- Arithmetic:
  - Digits are always legal BCD; no state outside 00..59 is reachable.
  - Carry and borrow are computed combinationally from the current digits; the result is registered.
- tick_hour:
  - A registered pulse: high in the cycle after the edge that wrapped to 00; never wider than one cycle.
  - Back-to-back tick_minute pulses are legal. Each pulse is counted, and at most one of them can produce a rollover.
- Latency: tick_minute to updated digits is 1 cycle; the rollover tick to tick_hour is 1 cycle.

Decomposition:
- Shared package clock_pkg:
  - BCD digit typedef (4 bits).
  - Constants MIN_UNIT_MAX=9 and MIN_TEN_MAX=5.
  - Mode encoding constants RUN=1 and SET=0, shared with the seconds and hours stages.
- Sub-module bcd_mod60:
  - Pure combinational next-value logic.
  - Inputs: unit, ten, inc, dec. Outputs: next unit, next ten, wrap flag.
  - Reusable by the seconds stage.
- The registers, prescaler and tick_hour generation remain in counter_minutes.

Test Plan:
- Reset then run:
  - Stimulus: rst=1 for 2 cycles, release, mode=1, 60 single-cycle tick_minute pulses spaced 3 cycles apart.
  - Response: the value steps 00→01…59→00, and tick_hour is high exactly one cycle, one cycle after the 60th tick.
- Set-mode increment with wrap:
  - Stimulus: preload 58 via ticks, mode=0, up=1 held 3 cycles (ADJ_DIV=1).
  - Response: value reads 59, 00, 01; tick_hour stays 0 and concurrent tick_minute pulses are ignored.
- Set-mode decrement with borrow:
  - Stimulus: from 10, down=1 for 12 cycles.
  - Response: value reads 09, 08, …, 00, 59, 58, with no tick_hour.
- Conflict and prescaler:
  - Stimulus: ADJ_DIV=4, up=down=1 for 20 cycles, then up only for 8 cycles.
  - Response: the value holds for all 20 cycles, then advances by exactly 2, at cycles 4 and 8.
- Asynchronous reset mid-operation:
  - Stimulus: at 37 in run mode, assert rst between clock edges, coincident with a tick.
  - Response: outputs go to 00 and tick_hour=0 immediately, without waiting for a clock edge; the tick is lost.
- Mode boundary:
  - Stimulus: tick_minute in the same cycle as a mode 0→1 switch at 59.
  - Response: value goes to 00 and tick_hour pulses once on the next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock chain (seconds, minutes and hours stages).
//   bcd_t         : one BCD digit
//   MIN_UNIT_MAX  : largest units digit of a minute/second value
//   MIN_TEN_MAX   : largest tens digit of a minute/second value
//   RUN / SET     : encoding of the per-stage mode input
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MIN_UNIT_MAX = 4'd9;
    localparam bcd_t MIN_TEN_MAX  = 4'd5;

    localparam logic RUN = 1'b1;
    localparam logic SET = 1'b0;

endpackage

// File: rtl/bcd_mod60.sv
// Combinational next-value logic for a two-digit BCD counter modulo 60.
// Ports:
//   unit, ten           : current BCD digits (00..59)
//   inc, dec            : step request; when both or neither are set, the value holds
//   next_unit, next_ten : digits after the requested step
//   wrap                : the step crosses 59->00 (inc) or 00->59 (dec)
module bcd_mod60
    import clock_pkg::*;
(
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] next_unit,
    output logic [3:0] next_ten,
    output logic       wrap
);

    // Carry out of the units digit feeds the tens digit, and carry out of
    // the tens digit is the wrap flag. Borrow works the same way downwards.
    always_comb begin
        next_unit = unit;
        next_ten  = ten;
        wrap      = 1'b0;
        if (inc && !dec) begin
            if (unit >= MIN_UNIT_MAX) begin
                next_unit = 4'd0;
                if (ten >= MIN_TEN_MAX) begin
                    next_ten = 4'd0;
                    wrap     = 1'b1;
                end else begin
                    next_ten = ten + 4'd1;
                end
            end else begin
                next_unit = unit + 4'd1;
            end
        end else if (dec && !inc) begin
            if (unit == 4'd0) begin
                next_unit = MIN_UNIT_MAX;
                if (ten == 4'd0) begin
                    next_ten = MIN_TEN_MAX;
                    wrap     = 1'b1;
                end else begin
                    next_ten = ten - 4'd1;
                end
            end else begin
                next_unit = unit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/counter_minutes.sv
// Minutes stage of the clock chain.
// In run mode the BCD minute value advances on each tick_minute pulse and a
// one-cycle tick_hour pulse follows the 59->00 rollover. In set mode ticks
// are dropped and up/down step the value once every ADJ_DIV cycles.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   mode_minute  : 1 = run, 0 = set
//   tick_minute  : one-cycle pulse from the seconds stage
//   up, down     : level-sensitive adjust requests (set mode only)
//   minute_unit  : BCD units digit, 0..9
//   minute_ten   : BCD tens digit, 0..5
//   tick_hour    : registered one-cycle rollover pulse for the hours stage
module counter_minutes
    import clock_pkg::*;
#(
    parameter int ADJ_DIV = 1,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_minute,
    input  logic       tick_minute,
    input  logic       up,
    input  logic       down,
    output logic [3:0] minute_unit,
    output logic [3:0] minute_ten,
    output logic       tick_hour
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ADJ_DIV - 1);

    bcd_t             unit_q;
    bcd_t             ten_q;
    bcd_t             next_unit;
    bcd_t             next_ten;
    logic             wrap;
    logic             inc;
    logic             dec;
    logic             adjust_req;
    logic             step_en;
    logic             tick_hour_q;
    logic [DIV_W-1:0] prescaler;

    // A valid adjust request needs set mode and exactly one of up/down.
    // Anything else (including run mode) keeps the prescaler at zero, which
    // also gives the "mode switch clears the prescaler" behaviour for free.
    always_comb begin
        adjust_req = (mode_minute == SET) && (up != down);
        step_en    = adjust_req && (prescaler == DIV_LAST);
    end

    // Mode is sampled on the same edge as the tick, so a tick arriving with
    // the 0->1 mode change is counted.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        if (mode_minute == RUN) begin
            inc = tick_minute;
        end else begin
            inc = step_en && up;
            dec = step_en && down;
        end
    end

    bcd_mod60 u_mod60 (
        .unit      (unit_q),
        .ten       (ten_q),
        .inc       (inc),
        .dec       (dec),
        .next_unit (next_unit),
        .next_ten  (next_ten),
        .wrap      (wrap)
    );

    // Adjust prescaler: reloads on each step, clears whenever the request
    // is absent, conflicting, or the block is in run mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (!adjust_req || step_en) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit registers and the rollover pulse. Only a run-mode wrap (which
    // can only be 59->00) produces tick_hour; set-mode wraps stay silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_q      <= 4'd0;
            ten_q       <= 4'd0;
            tick_hour_q <= 1'b0;
        end else begin
            unit_q      <= next_unit;
            ten_q       <= next_ten;
            tick_hour_q <= (mode_minute == RUN) && tick_minute && wrap;
        end
    end

    assign minute_unit = unit_q;
    assign minute_ten  = ten_q;
    assign tick_hour   = tick_hour_q;

endmodule

// File: tb/tb_counter_minutes.sv
// Directed bench for counter_minutes. Two instances share the stimulus:
// dut1 (ADJ_DIV=1) for most scenarios, dut4 (ADJ_DIV=4) for prescaler cadence.
module tb_counter_minutes;

    logic       clk;
    logic       rst;
    logic       mode_minute;
    logic       tick_minute;
    logic       up;
    logic       down;
    logic [3:0] unit1, ten1, unit4, ten4;
    logic       th1, th4;

    int errors;
    int checks;

    counter_minutes #(.ADJ_DIV(1), .DIV_W(16)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .mode_minute (mode_minute),
        .tick_minute (tick_minute),
        .up          (up),
        .down        (down),
        .minute_unit (unit1),
        .minute_ten  (ten1),
        .tick_hour   (th1)
    );

    counter_minutes #(.ADJ_DIV(4), .DIV_W(16)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .mode_minute (mode_minute),
        .tick_minute (tick_minute),
        .up          (up),
        .down        (down),
        .minute_unit (unit4),
        .minute_ten  (ten4),
        .tick_hour   (th4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ten1, unit1} !== 8'h00 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %0d%0d th=%0b, expected 00 th=0", ten1, unit1, th1);
        end
        checks++;
        if ({ten4, unit4} !== 8'h00 || th4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut4: got %0d%0d th=%0b, expected 00 th=0", ten4, unit4, th4);
        end
        rst = 1'b0;
    endtask

    task automatic test_run();
        int v;
        mode_minute = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            v = i % 60;
            tick_minute = 1'b1;
            step();
            tick_minute = 1'b0;
            checks++;
            if (ten1 !== 4'(v / 10) || unit1 !== 4'(v % 10) || th1 !== (i == 60)) begin
                errors++;
                $display("[TB] FAIL run_tick%0d: got %0d%0d th=%0b, expected %0d%0d th=%0b",
                         i, ten1, unit1, th1, v / 10, v % 10, (i == 60));
            end
            step();
            checks++;
            if (ten1 !== 4'(v / 10) || unit1 !== 4'(v % 10) || th1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL run_gap%0d: got %0d%0d th=%0b, expected %0d%0d th=0",
                         i, ten1, unit1, th1, v / 10, v % 10);
            end
            step();
        end
        checks++;
        if ({ten4, unit4} !== 8'h00 || th4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_dut4_end: got %0d%0d th=%0b, expected 00 th=0", ten4, unit4, th4);
        end
    endtask

    task automatic test_set_inc();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h59;
        exp_v[1] = 8'h00;
        exp_v[2] = 8'h01;
        tick_minute = 1'b1;
        repeat (58) step();
        checks++;
        if ({ten1, unit1} !== 8'h58) begin
            errors++;
            $display("[TB] FAIL preload58: got %0d%0d, expected 58", ten1, unit1);
        end
        // Ticks stay asserted: they must be dropped in set mode.
        mode_minute = 1'b0;
        up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({ten1, unit1} !== exp_v[k] || th1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL set_inc%0d: got %0d%0d th=%0b, expected %h th=0",
                         k, ten1, unit1, th1, exp_v[k]);
            end
        end
        up = 1'b0;
        tick_minute = 1'b0;
        step();
        checks++;
        if ({ten1, unit1} !== 8'h01) begin
            errors++;
            $display("[TB] FAIL set_release_hold: got %0d%0d, expected 01", ten1, unit1);
        end
    endtask

    task automatic test_set_dec();
        int v;
        up = 1'b1;
        repeat (9) step();
        up = 1'b0;
        checks++;
        if ({ten1, unit1} !== 8'h10) begin
            errors++;
            $display("[TB] FAIL preload10: got %0d%0d, expected 10", ten1, unit1);
        end
        down = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            v = (10 - k + 60) % 60;
            step();
            checks++;
            if (ten1 !== 4'(v / 10) || unit1 !== 4'(v % 10) || th1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL set_dec%0d: got %0d%0d th=%0b, expected %0d%0d th=0",
                         k, ten1, unit1, th1, v / 10, v % 10);
            end
        end
        down = 1'b0;
    endtask

    task automatic test_conflict_prescaler();
        int v;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode_minute = 1'b0;
        up = 1'b1;
        down = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if ({ten4, unit4} !== 8'h00 || {ten1, unit1} !== 8'h00) begin
                errors++;
                $display("[TB] FAIL conflict%0d: got dut4=%0d%0d dut1=%0d%0d, expected 00",
                         k, ten4, unit4, ten1, unit1);
            end
        end
        down = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            v = k / 4;
            step();
            checks++;
            if (ten4 !== 4'd0 || unit4 !== 4'(v) || th4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL prescale%0d: got %0d%0d th=%0b, expected 0%0d th=0",
                         k, ten4, unit4, th4, v);
            end
        end
        up = 1'b0;
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode_minute = 1'b1;
        tick_minute = 1'b1;
        repeat (37) step();
        checks++;
        if ({ten1, unit1} !== 8'h37) begin
            errors++;
            $display("[TB] FAIL back_to_back37: got %0d%0d, expected 37", ten1, unit1);
        end
        // Tick still high; reset lands between edges.
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({ten1, unit1} !== 8'h00 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_now: got %0d%0d th=%0b, expected 00 th=0", ten1, unit1, th1);
        end
        step();
        checks++;
        if ({ten1, unit1} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset_hold: got %0d%0d, expected 00", ten1, unit1);
        end
        rst = 1'b0;
        tick_minute = 1'b0;
        step();
        checks++;
        if ({ten1, unit1} !== 8'h00 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_tick_lost: got %0d%0d th=%0b, expected 00 th=0", ten1, unit1, th1);
        end
    endtask

    task automatic test_mode_boundary();
        mode_minute = 1'b0;
        down = 1'b1;
        step();
        down = 1'b0;
        checks++;
        if ({ten1, unit1} !== 8'h59 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL set_wrap_down: got %0d%0d th=%0b, expected 59 th=0", ten1, unit1, th1);
        end
        tick_minute = 1'b1;
        step();
        checks++;
        if ({ten1, unit1} !== 8'h59 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL set_tick_dropped: got %0d%0d th=%0b, expected 59 th=0", ten1, unit1, th1);
        end
        mode_minute = 1'b1;
        step();
        tick_minute = 1'b0;
        checks++;
        if ({ten1, unit1} !== 8'h00 || th1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mode_edge_tick: got %0d%0d th=%0b, expected 00 th=1", ten1, unit1, th1);
        end
        step();
        checks++;
        if ({ten1, unit1} !== 8'h00 || th1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode_edge_pulse_width: got %0d%0d th=%0b, expected 00 th=0", ten1, unit1, th1);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        mode_minute = 1'b1;
        tick_minute = 1'b0;
        up          = 1'b0;
        down        = 1'b0;
        test_reset();
        test_run();
        test_set_inc();
        test_set_dec();
        test_conflict_prescaler();
        test_async_reset();
        test_mode_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
